// File: rtl/demux_1_4_8_bit.sv
// 1-to-4 demultiplexer with per-channel holding registers and valid/ack handshake.
// Optional DEMUX_AUTO_SEL_EN adds i_auto and a round-robin destination pointer.
module demux_1_4_8_bit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
`ifdef DEMUX_AUTO_SEL_EN
    input  logic             i_auto,
`endif
    input  logic [WIDTH-1:0] i_code,
    input  logic [1:0]       i_sel_code,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_code_0,
    output logic [WIDTH-1:0] o_code_1,
    output logic [WIDTH-1:0] o_code_2,
    output logic [WIDTH-1:0] o_code_3,
    output logic [3:0]       o_valid,
    input  logic [3:0]       i_ack,
    output logic             o_full,
    output logic [7:0]       o_xfer_cnt
);

    localparam int unsigned NCH   = 4;
    localparam int unsigned CNT_W = 8;

    logic [WIDTH-1:0] r_code [NCH];
    logic [NCH-1:0]   r_valid;
    logic [CNT_W-1:0] r_xfer_cnt;

    logic [1:0]       w_tgt;
    logic             w_xfer;
    logic [NCH-1:0]   w_load;
    logic [NCH-1:0]   w_valid_nxt;

`ifdef DEMUX_AUTO_SEL_EN
    logic [1:0]       r_ptr;

    // Round-robin pointer advances only on transfers made in auto mode.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= 2'd0;
        end else if (w_xfer && i_auto) begin
            r_ptr <= r_ptr + 2'd1;
        end
    end

    assign w_tgt = i_auto ? r_ptr : i_sel_code;
`else
    assign w_tgt = i_sel_code;
`endif

    // A slot is writable when empty or being drained this same cycle.
    assign o_ready = i_rst_n & i_en & (~r_valid[w_tgt] | i_ack[w_tgt]);
    assign w_xfer  = i_valid & o_ready;

    always_comb begin
        w_load = '0;
        if (w_xfer) begin
            w_load[w_tgt] = 1'b1;
        end
        // Load wins over ack so a same-cycle refill never drops data.
        w_valid_nxt = (r_valid & ~i_ack) | w_load;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                r_code[k] <= '0;
            end
            r_valid    <= '0;
            r_xfer_cnt <= '0;
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                if (w_load[k]) begin
                    r_code[k] <= i_code;
                end
            end
            r_valid <= w_valid_nxt;
            if (w_xfer) begin
                r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
            end
        end
    end

    assign o_code_0   = r_code[0];
    assign o_code_1   = r_code[1];
    assign o_code_2   = r_code[2];
    assign o_code_3   = r_code[3];
    assign o_valid    = r_valid;
    assign o_full     = &r_valid;
    assign o_xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_demux_1_4_8_bit.sv
// Scoreboard bench for demux_1_4_8_bit: behavioural model predicts ready/valid/count,
// accepted words are queued at drive time and popped when the channel register updates.
module tb_demux_1_4_8_bit;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] code;
    logic [1:0] sel;
    logic       valid;
    logic       ready;
    logic [7:0] code0, code1, code2, code3;
    logic [3:0] vld;
    logic [3:0] ack;
    logic       full;
    logic [7:0] cnt;
`ifdef DEMUX_AUTO_SEL_EN
    logic       auto_sel;
`endif

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q [$];
    logic [7:0] m_code [4];
    logic [3:0] m_valid;
    logic [7:0] m_cnt;
    logic [1:0] m_ptr;
    int         checks;
    int         errors;

    demux_1_4_8_bit #(.WIDTH(8)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
`ifdef DEMUX_AUTO_SEL_EN
        .i_auto     (auto_sel),
`endif
        .i_code     (code),
        .i_sel_code (sel),
        .i_valid    (valid),
        .o_ready    (ready),
        .o_code_0   (code0),
        .o_code_1   (code1),
        .o_code_2   (code2),
        .o_code_3   (code3),
        .o_valid    (vld),
        .i_ack      (ack),
        .o_full     (full),
        .o_xfer_cnt (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_code(input logic [1:0] ch);
        case (ch)
            2'd0:    return code0;
            2'd1:    return code1;
            2'd2:    return code2;
            default: return code3;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_code[k] = 8'h00;
        m_valid = 4'b0000;
        m_cnt   = 8'h00;
        m_ptr   = 2'd0;
        sb_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_code0"}, code0, 8'h00);
        check({tag, "_code1"}, code1, 8'h00);
        check({tag, "_code2"}, code2, 8'h00);
        check({tag, "_code3"}, code3, 8'h00);
        check({tag, "_valid"}, 8'(vld), 8'h00);
        check({tag, "_cnt"}, cnt, 8'h00);
        check({tag, "_ready"}, 8'(ready), 8'h00);
        check({tag, "_full"}, 8'(full), 8'h00);
    endtask

    // One clock cycle: called just after a rising edge, drives, checks combinational
    // outputs before the next edge, then checks registered state after it.
    task automatic cycle(input logic v, input logic [1:0] s, input logic [7:0] d,
                         input logic [3:0] a, input logic e);
        logic [1:0] t;
        logic       m_ready;
        logic       xfer;
        exp_t       item;
        valid = v; sel = s; code = d; ack = a; en = e;
        t = s;
`ifdef DEMUX_AUTO_SEL_EN
        if (auto_sel) t = m_ptr;
`endif
        #1;
        m_ready = e & (~m_valid[t] | a[t]);
        xfer    = v & m_ready;
        check("ready", 8'(ready), 8'(m_ready));
        check("full", 8'(full), 8'(&m_valid));
        if (xfer) sb_q.push_back('{ch: t, data: d});
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (xfer && t == 2'(k)) begin
                m_valid[k] = 1'b1;
                m_code[k]  = d;
            end else if (a[k]) begin
                m_valid[k] = 1'b0;
            end
        end
        if (xfer) begin
            m_cnt = m_cnt + 8'd1;
`ifdef DEMUX_AUTO_SEL_EN
            if (auto_sel) m_ptr = m_ptr + 2'd1;
`endif
        end
        if (sb_q.size() > 0) begin
            item = sb_q.pop_front();
            check("sb_data", dut_code(item.ch), item.data);
            check("sb_valid", 8'(vld[item.ch]), 8'h01);
        end
        check("valid", 8'(vld), 8'(m_valid));
        check("cnt", cnt, m_cnt);
        for (int k = 0; k < 4; k++) check("code_hold", dut_code(2'(k)), m_code[k]);
        valid = 1'b0; ack = 4'b0000;
    endtask

    initial begin
        logic [7:0] cnt_start;
        checks = 0; errors = 0;
        rst_n = 1'b0; en = 1'b0; valid = 1'b0; code = 8'h00; sel = 2'd0; ack = 4'b0000;
`ifdef DEMUX_AUTO_SEL_EN
        auto_sel = 1'b0;
`endif
        model_reset();
        #3;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic transfer to channel 2
        cycle(1'b1, 2'd2, 8'hC0, 4'b0000, 1'b1);
        check("c0_code2", code2, 8'hC0);
        check("c0_cnt", cnt, 8'h01);

        // Occupied channel refuses, then ack + refill in the same cycle
        cycle(1'b1, 2'd1, 8'h11, 4'b0000, 1'b1);
        cycle(1'b1, 2'd1, 8'h40, 4'b0000, 1'b1);
        check("blocked_code1", code1, 8'h11);
        cycle(1'b1, 2'd1, 8'h40, 4'b0010, 1'b1);
        check("refill_code1", code1, 8'h40);

        // Fill all four, refuse when full, drain with one ack cycle
        cycle(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1);
        cycle(1'b1, 2'd0, 8'h80, 4'b0000, 1'b1);
        cycle(1'b1, 2'd1, 8'h40, 4'b0000, 1'b1);
        cycle(1'b1, 2'd2, 8'hC0, 4'b0000, 1'b1);
        cycle(1'b1, 2'd3, 8'h20, 4'b0000, 1'b1);
        check("full_set", 8'(full), 8'h01);
        cycle(1'b1, 2'd2, 8'hFF, 4'b0000, 1'b1);
        cycle(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1);
        check("drained_full", 8'(full), 8'h00);
        check("retain_code3", code3, 8'h20);

        // Ack on empty channels is ignored; disabled block refuses but still drains
        cycle(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1);
        cycle(1'b1, 2'd0, 8'h55, 4'b0000, 1'b0);
        cycle(1'b1, 2'd0, 8'h66, 4'b0000, 1'b1);
        cycle(1'b0, 2'd0, 8'h00, 4'b0001, 1'b0);

        // 256 transfers wrap the counter back to its start value
        cnt_start = m_cnt;
        for (int i = 0; i < 256; i++) cycle(1'b1, 2'd0, 8'(i), 4'b0001, 1'b1);
        check("cnt_wrap", cnt, cnt_start);

        // Asynchronous reset between edges with data on channels 1 and 3
        cycle(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1);
        cycle(1'b1, 2'd1, 8'hA1, 4'b0000, 1'b1);
        cycle(1'b1, 2'd3, 8'hA3, 4'b0000, 1'b1);
        check("pre_rst_valid", 8'(vld), 8'h0A);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        en = 1'b1; valid = 1'b1; sel = 2'd0; code = 8'hAA;
        @(posedge clk); #1;
        check("rst_edge_valid", 8'(vld), 8'h00);
        check("rst_edge_code0", code0, 8'h00);
        valid = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(1'b1, 2'd0, 8'h5A, 4'b0000, 1'b1);
        check("post_rst_code0", code0, 8'h5A);

`ifdef DEMUX_AUTO_SEL_EN
        // Auto pointer walks 0,1,2,3,0 regardless of i_sel_code
        cycle(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1);
        auto_sel = 1'b1;
        for (int i = 1; i <= 5; i++) cycle(1'b1, 2'd3, 8'(i), 4'b1111, 1'b1);
        check("auto_code0", code0, 8'h05);
        check("auto_code3", code3, 8'h04);
        auto_sel = 1'b0;
`endif

        check("sb_empty", 8'(sb_q.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_1_4_8_bit.md
DEMUX_1_4_8_BIT -- requirements
Module: demux_1_4_8_bit

Interface
REQ-001 Parameter: WIDTH, default 8, data width of input and each output channel.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_en  input  1  block enable; 0 = no transfer accepted, stored state held.
REQ-005 i_code  input  WIDTH  input data word.
REQ-006 i_sel_code  input  2  destination channel 0..3.
REQ-007 i_valid  input  1  i_code/i_sel_code valid this cycle.
REQ-008 o_ready  output  1  block accepts the presented word this cycle.
REQ-009 o_code_0 .. o_code_3  output  WIDTH each  per-channel holding registers.
REQ-010 o_valid  output  4  bit k = o_code_k holds unconsumed data.
REQ-011 i_ack  input  4  bit k = consumer takes o_code_k this cycle.
REQ-012 o_full  output  1  all four channels hold unconsumed data.
REQ-013 o_xfer_cnt  output  8  count of accepted transfers.

Function
REQ-014 Target channel t SHALL be i_sel_code (or the auto pointer per REQ-029).
REQ-015 o_ready SHALL be combinational: i_rst_n & i_en & (~o_valid[t] | i_ack[t]).
REQ-016 A transfer SHALL occur on a rising edge where i_valid & o_ready = 1.
REQ-017 On transfer, o_code_t <= i_code and o_valid[t] <= 1 at that edge; latency 1 cycle; other channels unchanged.
REQ-018 o_valid[k] SHALL clear at an edge where i_ack[k] & o_valid[k] and no transfer targets k.
REQ-019 Simultaneous ack and transfer on the same channel: o_valid[k] stays 1, o_code_k takes the new word, no data lost.
REQ-020 i_ack[k] while o_valid[k] = 0 SHALL be ignored.
REQ-021 o_code_k SHALL retain its last value after ack; it is not cleared.
REQ-022 i_valid with o_ready = 0 (channel occupied, no ack, or i_en = 0): no state change; source holds the word.
REQ-023 o_full SHALL equal &o_valid, combinational.
REQ-024 o_xfer_cnt SHALL increment by 1 per transfer, wrapping 255 -> 0.
REQ-025 i_en = 0 SHALL NOT block acks; o_valid bits still clear per REQ-018.

Reset
REQ-026 While i_rst_n = 0: o_code_0..3 = 0, o_valid = 4'b0000, o_xfer_cnt = 0, auto pointer = 0, o_ready = 0, o_full = 0; takes effect immediately, independent of i_clk.
REQ-027 Reset asserted mid-operation SHALL discard all held data; a transfer on the edge coinciding with reset SHALL NOT be accepted.
REQ-028 After i_rst_n rises, the first transfer is accepted on the first rising edge satisfying REQ-016.

Configuration
REQ-029 With macro DEMUX_AUTO_SEL_EN defined: input i_auto (1 bit) exists; when i_auto = 1, t = internal 2-bit pointer, which increments mod 4 (3 -> 0) on each accepted transfer; when i_auto = 0, t = i_sel_code and the pointer holds its value.
REQ-030 Without DEMUX_AUTO_SEL_EN: no i_auto port and no pointer; t = i_sel_code always.

Verification
REQ-031 Reset, then i_en=1, i_valid=1, i_sel_code=2, i_code=8'hC0 for one cycle -> next cycle o_code_2=8'hC0, o_valid=4'b0100, o_xfer_cnt=1.
REQ-032 Channel 1 occupied, no ack, write to sel=1 with 8'h40 -> o_ready=0, o_code_1 unchanged; assert i_ack[1] same cycle -> o_ready=1, o_code_1=8'h40, o_valid[1] stays 1.
REQ-033 Fill sel 0,1,2,3 with 8'h80,8'h40,8'hC0,8'h20 -> o_full=1, further writes refused; i_ack=4'b1111 one cycle -> o_valid=0, o_full=0, data retained.
REQ-034 i_en=0 with i_valid=1 -> o_ready=0, no change; 256 transfers -> o_xfer_cnt wraps to 0.
REQ-035 Assert i_rst_n=0 between clock edges while o_valid=4'b1010 -> outputs zero immediately, before next edge.
REQ-036 (DEMUX_AUTO_SEL_EN) i_auto=1, five transfers 8'h01..8'h05 with acks -> channels 0,1,2,3,0 receive them; o_code_0=8'h05.
